// File: rtl/sclk_shifter.sv
// sclk_shifter: serializes one WORD_WIDTH word MSB first onto sout, updating
// sout/lat only on SCLK falling edges so both are stable at every SCLK rise.
// lat is high on the trailing min(lat_len, WORD_WIDTH) rising edges of a word.
module sclk_shifter #(
    parameter int unsigned WORD_WIDTH = 48,
    parameter int unsigned LEN_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic [WORD_WIDTH-1:0] data,
    input  logic [LEN_WIDTH-1:0]  lat_len,
    input  logic                  valid,
    output logic                  ready,
    output logic                  sout,
    output logic                  lat,
    output logic                  done
);

    localparam int unsigned CNT_W = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_FALL = 2'd1;
    localparam logic [1:0] SHIFT     = 2'd2;
    localparam logic [1:0] FINISH    = 2'd3;

    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(WORD_WIDTH);
    localparam logic [CNT_W-1:0]     CNT_TOP = CNT_W'(WORD_WIDTH - 1);

    logic [1:0]            state, state_nxt;
    logic                  sclk_q;
    logic [WORD_WIDTH-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [LEN_WIDTH-1:0]  lat_cnt, lat_cnt_nxt;
    logic                  sout_nxt, lat_nxt, done_nxt, ready_nxt;
    logic                  fall;

    // SCLK falling edge seen in the clk domain
    assign fall = ~sclk & sclk_q;

    // Next-state and next-output logic; cnt holds the index of the bit on sout
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        cnt_nxt     = cnt;
        lat_cnt_nxt = lat_cnt;
        sout_nxt    = sout;
        lat_nxt     = lat;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (valid && ready) begin
                    shreg_nxt   = data;
                    lat_cnt_nxt = (lat_len > LEN_MAX) ? LEN_MAX : lat_len;
                    state_nxt   = WAIT_FALL;
                end
            end
            WAIT_FALL: begin
                if (fall) begin
                    sout_nxt  = shreg[WORD_WIDTH-1];
                    shreg_nxt = {shreg[WORD_WIDTH-2:0], 1'b0};
                    cnt_nxt   = CNT_TOP;
                    lat_nxt   = LEN_WIDTH'(CNT_TOP) < lat_cnt;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (fall) begin
                    if (cnt != '0) begin
                        sout_nxt  = shreg[WORD_WIDTH-1];
                        shreg_nxt = {shreg[WORD_WIDTH-2:0], 1'b0};
                        cnt_nxt   = cnt - CNT_W'(1);
                        // new index is cnt-1; high when cnt-1 < lat_cnt
                        lat_nxt   = LEN_WIDTH'(cnt) <= lat_cnt;
                    end else begin
                        sout_nxt  = 1'b0;
                        lat_nxt   = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = FINISH;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        ready_nxt = (state_nxt == IDLE);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sclk_q  <= 1'b0;
            shreg   <= '0;
            cnt     <= '0;
            lat_cnt <= '0;
            sout    <= 1'b0;
            lat     <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b1;
        end else begin
            state   <= state_nxt;
            sclk_q  <= sclk;
            shreg   <= shreg_nxt;
            cnt     <= cnt_nxt;
            lat_cnt <= lat_cnt_nxt;
            sout    <= sout_nxt;
            lat     <= lat_nxt;
            done    <= done_nxt;
            ready   <= ready_nxt;
        end
    end

endmodule

// File: tb/tb_sclk_shifter.sv
// tb_sclk_shifter: directed checks of sclk_shifter with an LED-driver model
// that samples sout/lat on every SCLK rising edge.
module tb_sclk_shifter;

    localparam int unsigned W  = 48;
    localparam int unsigned LW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          sclk = 1'b0;
    logic [W-1:0]  data;
    logic [LW-1:0] lat_len;
    logic          valid;
    logic          ready, sout, lat, done;

    int checks = 0;
    int errors = 0;

    int sclk_half  = 4;
    int div_cnt    = 0;
    int rise_total = 0;
    int done_total = 0;
    int done_rise  = 0;
    int gap_bad    = 0;
    logic         post_done = 1'b0;
    logic [W-1:0] rx_data   = '0;
    logic [W-1:0] rx_lat    = '0;
    logic [W-1:0] done_data = '0;
    logic [W-1:0] done_lat  = '0;

    sclk_shifter #(.WORD_WIDTH(W), .LEN_WIDTH(LW)) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .data    (data),
        .lat_len (lat_len),
        .valid   (valid),
        .ready   (ready),
        .sout    (sout),
        .lat     (lat),
        .done    (done)
    );

    always #5 clk = ~clk;

    // SCLK generator plus driver model: shift sout/lat in at each SCLK rise
    always @(negedge clk) begin
        if (done) begin
            done_total = done_total + 1;
            done_data  = rx_data;
            done_lat   = rx_lat;
            done_rise  = rise_total;
            post_done  = 1'b1;
        end
        div_cnt = div_cnt + 1;
        if (div_cnt >= sclk_half) begin
            div_cnt = 0;
            if (!sclk) begin
                rx_data    = {rx_data[W-2:0], sout};
                rx_lat     = {rx_lat[W-2:0], lat};
                rise_total = rise_total + 1;
                if (post_done) begin
                    if (lat !== 1'b0) gap_bad = gap_bad + 1;
                    post_done = 1'b0;
                end
            end
            sclk = ~sclk;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] lat_mask(input int n);
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < W; i++) if (i < n) m[i] = 1'b1;
        return m;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic [LW-1:0] len, input string tag);
        int t;
        int r0;
        int d0;
        int n;
        t = 0;
        while (!ready && t < 1000) begin tick(); t++; end
        check({tag, " ready_in"}, 64'(ready), 64'(1));
        data    = d;
        lat_len = len;
        valid   = 1'b1;
        r0 = rise_total;
        d0 = done_total;
        tick();
        valid   = 1'b0;
        data    = ~d;
        lat_len = ~len;
        t = 0;
        while (done_total == d0 && t < 2000) begin tick(); t++; end
        check({tag, " done_seen"}, 64'(done_total != d0), 64'(1));
        check({tag, " data"}, 64'(done_data), 64'(d));
        n = (int'(len) > W) ? W : int'(len);
        check({tag, " lat"}, 64'(done_lat), 64'(lat_mask(n)));
        check({tag, " edges"}, 64'((done_rise - r0 == W) || (done_rise - r0 == W + 1)), 64'(1));
        repeat (4) tick();
        check({tag, " done_pulse"}, 64'(done_total - d0), 64'(1));
        check({tag, " ready_out"}, 64'(ready), 64'(1));
    endtask

    // valid held high with data changing every cycle; words accepted are queued
    task automatic run_stream();
        logic [W-1:0] q[$];
        logic [W-1:0] pat;
        logic [W-1:0] exp;
        int got;
        int pushed;
        int t;
        int dprev;
        got    = 0;
        pushed = 0;
        t      = 0;
        dprev  = done_total;
        pat    = 48'h0F0F_1111_0000;
        lat_len = 6'd2;
        while ((got < 3 || got < pushed) && t < 8000) begin
            pat   = pat + 48'h0101_0203_0405;
            data  = pat;
            valid = (got < 3);
            if (valid && ready) begin
                q.push_back(pat);
                pushed++;
            end
            tick();
            t++;
            if (done_total != dprev) begin
                dprev = done_total;
                got++;
                if (q.size() > 0) begin
                    exp = q.pop_front();
                    check("stream data", 64'(done_data), 64'(exp));
                    check("stream lat", 64'(done_lat), 64'(lat_mask(2)));
                end else begin
                    check("stream spurious_done", 64'(0), 64'(1));
                end
            end
        end
        valid = 1'b0;
        check("stream words", 64'(got), 64'(pushed));
        check("stream min_words", 64'(got >= 3), 64'(1));
    endtask

    initial begin
        int t;
        int r0;
        int d0;
        rst     = 1'b1;
        valid   = 1'b0;
        data    = '0;
        lat_len = '0;
        repeat (3) tick();
        check("reset ready", 64'(ready), 64'(1));
        check("reset sout", 64'(sout), 64'(0));
        check("reset lat", 64'(lat), 64'(0));
        check("reset done", 64'(done), 64'(0));
        rst = 1'b0;
        repeat (5) tick();

        send_word(48'hA5A5_0000_FFFF, 6'd1, "nominal");
        send_word(48'h0000_0000_0000, 6'd3, "len3");
        send_word(48'hFFFF_FFFF_FFFF, 6'd0, "len0");
        send_word(48'h1234_5678_9ABC, 6'd63, "len63");
        repeat (20) tick();
        check("gap after words", 64'(gap_bad), 64'(0));

        run_stream();
        repeat (20) tick();
        check("gap after stream", 64'(gap_bad), 64'(0));

        // abort a word part-way through with lat active on every bit
        t = 0;
        while (!ready && t < 1000) begin tick(); t++; end
        data    = 48'hDEAD_BEEF_CAFE;
        lat_len = 6'd63;
        valid   = 1'b1;
        r0 = rise_total;
        tick();
        valid = 1'b0;
        t = 0;
        while ((rise_total - r0) < 29 && t < 2000) begin tick(); t++; end
        check("abort reached_bit20", 64'((rise_total - r0) >= 29), 64'(1));
        check("abort lat_before", 64'(lat), 64'(1));
        rst = 1'b1;
        d0 = done_total;
        tick();
        check("abort sout", 64'(sout), 64'(0));
        check("abort lat", 64'(lat), 64'(0));
        check("abort ready", 64'(ready), 64'(1));
        check("abort done", 64'(done), 64'(0));
        rst = 1'b0;
        repeat (40) tick();
        check("abort no_done", 64'(done_total - d0), 64'(0));
        check("abort lat_idle", 64'(lat), 64'(0));
        send_word(48'h8000_0000_0001, 6'd2, "post_rst");

        sclk_half = 1;
        repeat (4) tick();
        send_word(48'hA5A5_0000_FFFF, 6'd1, "fast");
        send_word(48'h5A5A_C3C3_0F0F, 6'd48, "fast_len48");
        repeat (10) tick();
        check("gap final", 64'(gap_bad), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
